// File: rtl/div5_reconstruct.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : div5_reconstruct                                              |
// | Purpose  : Sequential multiply-back for the divide-by-5 datapath.        |
// |            Rebuilds d = 5*q + r one radix-4 quotient digit per cycle,    |
// |            LSB first, through a 3-bit carry chain.                       |
// | Ports    : clk, rst_n        - clock, asynchronous active-low reset      |
// |            in_valid/in_ready - request handshake carrying q and r        |
// |            q [W-1:0], r[2:0] - quotient and remainder operands           |
// |            out_valid/out_ready - result handshake                        |
// |            d [W+2:0]         - reconstructed dividend                    |
// |            err               - sampled r was 5..7 (valid with out_valid) |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module div5_reconstruct #(
  parameter int unsigned W = 32  // quotient width; even and >= 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   q,
  input  logic [2:0]     r,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W+2:0]   d,
  output logic           err
);

  localparam int unsigned NDIG = W / 2;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  qs_q, qs_d;
  logic [2:0]    carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W+2:0]  res_q, res_d;
  logic          err_q, err_d;

  logic          accept_w;
  logic          last_w;
  logic [4:0]    t_w;
  logic [W+1:0]  shift_w;

  assign accept_w = (state_q == S_IDLE) && in_valid;
  assign last_w   = (cnt_q == CW'(NDIG - 1));

  // One digit step: 5*digit + carry peaks at 15 + 7 = 22, so 5 bits suffice
  // and the outgoing carry (t >> 2) stays within 3 bits even for r = 5..7.
  assign t_w = (5'd5 * {3'b000, qs_q[1:0]}) + {2'b00, carry_q};

  // New digit enters at the top of the low W bits; after W/2 steps the first
  // digit has walked down to bit 0.
  assign shift_w = {t_w[1:0], res_q[W-1:0]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid)  state_d = S_RUN;
      S_RUN:  if (last_w)    state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    d         = res_q;
    err       = err_q;
  end

  // Datapath next-state: only accept and RUN modify the registers, so the
  // result and err are held through DONE regardless of backpressure.
  always_comb begin
    qs_d    = qs_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    if (accept_w) begin
      qs_d    = q;
      carry_d = r;
      err_d   = (r >= 3'd5);
      cnt_d   = '0;
      res_d   = '0;
    end else if (state_q == S_RUN) begin
      res_d[W-1:0] = shift_w[W+1:2];
      carry_d      = t_w[4:2];
      qs_d         = qs_q >> 2;
      cnt_d        = cnt_q + 1'b1;
      if (last_w) begin
        res_d[W+2:W] = t_w[4:2];
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qs_q    <= '0;
      carry_q <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      qs_q    <= qs_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

endmodule
`default_nettype wire
